uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Sequences the UART transmitter from a TX holding FIFO.
- Accepts characters from the register-bus side and stores them in a FIFO.
- Issues one character at a time to the transmitter, using its pi_flag / busy_flag / po_flag handshake.
- Snapshots line configuration per character and reports 16550-style THRE/TEMT/overrun status.

Parameters:
- DEPTH, 16, FIFO depth in entries (power of two, >=2).
- AW, 4, log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe, one character per cycle
- wr_data  in  9  character to queue
- fifo_en  in  1  1 = DEPTH-entry FIFO; 0 = single holding register (effective depth 1)
- fifo_rst  in  1  synchronous flush pulse
- clr_overrun  in  1  clears overrun flag
- lcr_word_length  in  2  0..3 = 5..8 data bits
- lcr_parity_en  in  1  parity enable
- lcr_stop_bits  in  1  0 = 1 stop bit, 1 = 2 stop bits
- lcr_set_break  in  1  break request
- dll_baud_cnt  in  16  clocks per bit; 0 = transmitter disabled
- busy_flag  in  1  from transmitter, high while shifting
- po_flag  in  1  from transmitter, 1-cycle end-of-frame pulse
- pi_flag  out  1  1-cycle start pulse to transmitter
- pi_tx_data  out  9  character to transmitter
- word_length  out  2  latched config
- parity_en  out  1  latched config
- stop_bits  out  1  latched config
- baud_rate_cnt  out  16  latched config
- set_break  out  1  break to transmitter
- fifo_count  out  AW+1  entries queued
- thre  out  1  FIFO empty
- temt  out  1  FIFO empty and nothing transmitting
- overrun  out  1  sticky, write while full

Behaviour:
- Reset (async, rst_n=0): FIFO empty and pointers 0, FSM=IDLE.
  - All outputs 0, except thre=1 and temt=1.
  - Latched config resets to 0.
- FIFO:
  - full = (fifo_count==DEPTH) when fifo_en=1; (fifo_count==1) when fifo_en=0.
  - Pointers wrap modulo DEPTH.
  - Write while not full: stored, count+1.
  - Write while full: dropped, overrun<=1. Exception: if a pop occurs in the same cycle, the write is accepted and count is unchanged.
  - Write and pop in the same cycle when not full: count unchanged.
  - fifo_rst: pointers and count set to 0 next edge; overrides a same-cycle write and pop; does not abort the character in flight.
  - overrun: clr_overrun clears it. If a set and a clear occur in the same cycle, set wins.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE -> ISSUE when FIFO non-empty and dll_baud_cnt!=0 and set_break==0. On this edge:
    - register pi_flag<=1 and pi_tx_data<=head;
    - latch word_length, parity_en, stop_bits, baud_rate_cnt from the lcr/dll inputs;
    - pop the head.
  - ISSUE -> WAIT_DONE unconditionally; pi_flag<=0, so pi_flag is exactly 1 cycle wide.
  - WAIT_DONE on po_flag:
    - go to ISSUE directly (same rules as IDLE) if a character is eligible, giving back-to-back frames;
    - otherwise go to IDLE.
  - busy_flag is not used for sequencing; po_flag alone ends a frame.
  - A po_flag seen in IDLE or ISSUE is ignored.
- Latency: wr_en at edge N into an empty FIFO in IDLE -> pi_flag high in the cycle after edge N+1.
- Config stability: latched outputs change only on the ISSUE entry edge. lcr/dll changes mid-frame do not affect the current frame.
- Break:
  - set_break = lcr_set_break, registered 1 cycle.
  - While set_break=1, no new ISSUE is started; the current frame completes, and queued data is held.
- Status:
  - thre = (fifo_count==0).
  - temt = thre & (state==IDLE) & ~busy_flag; all terms registered-state or input, combinational OR-free.
- fifo_en change: takes effect immediately for full. Entries already stored beyond 1 remain and drain normally.

Test Plan:
- Single char: after reset, write 9'h0FF with dll=5208, wl=3, par=1 -> pi_flag 1 cycle at write+1 with pi_tx_data=0FF, baud_rate_cnt=5208, word_length=3; thre=1 immediately; temt=0 until po_flag, then 1.
- Burst: write 4 chars A,B,C,D back-to-back -> fifo_count peaks at 3; each po_flag triggers the next pi_flag on the following edge; output order A,B,C,D; 4 pulses total.
- Overflow: fifo_en=1, busy, write 17 chars -> 16 stored, overrun=1; clr_overrun -> overrun=0. fifo_en=0: second write while first is queued -> overrun=1.
- Config isolation: change lcr_word_length 3->0 during WAIT_DONE -> word_length stays 3 until the next ISSUE, then 0.
- Break/disable: lcr_set_break=1 with 2 queued -> no pi_flag; deassert -> issue resumes. dll_baud_cnt=0 with data queued -> stays in IDLE.
- Flush/reset: fifo_rst during WAIT_DONE with 5 queued -> count=0 next edge, in-flight frame completes, no further pi_flag. rst_n low mid-frame -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: TX holding FIFO, one-at-a-time issue to the transmitter,
// per-character line configuration snapshot and THRE/TEMT/overrun status.
module uart_tx_scheduler #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [8:0]    wr_data,
   input  logic          fifo_en,
   input  logic          fifo_rst,
   input  logic          clr_overrun,
   input  logic [1:0]    lcr_word_length,
   input  logic          lcr_parity_en,
   input  logic          lcr_stop_bits,
   input  logic          lcr_set_break,
   input  logic [15:0]   dll_baud_cnt,
   input  logic          busy_flag,
   input  logic          po_flag,
   output logic          pi_flag,
   output logic [8:0]    pi_tx_data,
   output logic [1:0]    word_length,
   output logic          parity_en,
   output logic          stop_bits,
   output logic [15:0]   baud_rate_cnt,
   output logic          set_break,
   output logic [AW:0]   fifo_count,
   output logic          thre,
   output logic          temt,
   output logic          overrun
);

   // state     | meaning
   // IDLE      | nothing in flight, waiting for an eligible character
   // ISSUE     | pi_flag cycle, character and config just handed over
   // WAIT_DONE | transmitter shifting, waiting for po_flag
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   state_t        state;
   state_t        state_nxt;
   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          eligible;
   logic          launch;
   logic          push;

   // With the FIFO disabled any stored entry makes it full, including leftovers
   // from FIFO mode, so the count can never grow past what is already queued.
   assign full     = fifo_en ? (fifo_count == FULL_CNT) : (fifo_count != '0);
   assign eligible = (fifo_count != '0) && (dll_baud_cnt != 16'd0) && !set_break && !fifo_rst;
   assign launch   = (state_nxt == ISSUE);
   assign push     = wr_en && (!full || launch) && !fifo_rst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (eligible) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_DONE;
         WAIT_DONE: if (po_flag) state_nxt = eligible ? ISSUE : IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pi_flag = (state == ISSUE);
      thre    = (fifo_count == '0);
      temt    = thre & (state == IDLE) & ~busy_flag;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (fifo_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (launch) rd_ptr <= rd_ptr + 1'b1;
         if (push && !launch)      fifo_count <= fifo_count + 1'b1;
         else if (!push && launch) fifo_count <= fifo_count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          overrun <= 1'b0;
      else if (wr_en && full && !launch)   overrun <= 1'b1;
      else if (clr_overrun)                overrun <= 1'b0;
   end

   // Config is snapshotted only on the edge entering ISSUE so a frame is never
   // disturbed by register writes made while it is on the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pi_tx_data    <= '0;
         word_length   <= '0;
         parity_en     <= 1'b0;
         stop_bits     <= 1'b0;
         baud_rate_cnt <= '0;
         set_break     <= 1'b0;
      end else begin
         set_break <= lcr_set_break;
         if (launch) begin
            pi_tx_data    <= mem[rd_ptr];
            word_length   <= lcr_word_length;
            parity_en     <= lcr_parity_en;
            stop_bits     <= lcr_stop_bits;
            baud_rate_cnt <= dll_baud_cnt;
         end
      end
   end

endmodule
